// File: rtl/frame_queue_scheduler.sv
// frame_queue_scheduler
//
// Purpose:
//   Merges two 17-bit word streams into one downstream queue. The streams come
//   from a camera and from a test-pattern generator. Only one source owns the
//   queue at a time, and ownership changes only on a frame boundary. If the
//   queue is full in the middle of a frame, the rest of that frame is dropped.
//   The frame is then closed with a single ABORT marker once the queue has
//   room again.
//
// Ports:
//   PixelClk   in   clock, rising edge
//   nRST       in   asynchronous active-low reset
//   src_sel    in   requested owner (0 = camera, 1 = test pattern), level
//   cam_data   in   camera word, bit16 = control flag
//   cam_wr_en  in   camera word valid
//   tp_data    in   test-pattern word, bit16 = control flag
//   tp_wr_en   in   test-pattern word valid
//   q_full     in   downstream queue full
//   ovf_clr    in   clears overflow and drop_count
//   q_data     out  registered word to the queue (holds its last value)
//   q_wr_en    out  registered queue write strobe
//   active_src out  current owner
//   overflow   out  sticky overflow flag
//   drop_count out  saturating count of dropped frames

module frame_queue_scheduler #(
  parameter int DROP_CNT_W = 8
) (
  input  logic                  PixelClk,
  input  logic                  nRST,
  input  logic                  src_sel,
  input  logic [16:0]           cam_data,
  input  logic                  cam_wr_en,
  input  logic [16:0]           tp_data,
  input  logic                  tp_wr_en,
  input  logic                  q_full,
  input  logic                  ovf_clr,
  output logic [16:0]           q_data,
  output logic                  q_wr_en,
  output logic                  active_src,
  output logic                  overflow,
  output logic [DROP_CNT_W-1:0] drop_count
);

  localparam logic [16:0] FRAME_START = 17'h10000;
  localparam logic [16:0] ABORT_WORD  = 17'h100FF;

  typedef enum logic [1:0] {
    S_IDLE,
    S_STREAM,
    S_DROP
  } state_t;

  state_t                  state_q, state_d;
  logic [16:0]             q_data_q, q_data_d;
  logic                    q_wr_en_q, q_wr_en_d;
  logic                    active_q, active_d;
  logic                    overflow_q, overflow_d;
  logic [DROP_CNT_W-1:0]   drop_q, drop_d;
  logic                    abort_pend_q, abort_pend_d;

  // The owner's word. The other source's traffic is never looked at.
  logic                    own_wr;
  logic [16:0]             own_data;
  logic                    own_fs;
  logic                    switch_pend;
  logic                    bump_drop;
  logic [DROP_CNT_W-1:0]   drop_inc;

  assign own_wr      = active_q ? tp_wr_en : cam_wr_en;
  assign own_data    = active_q ? tp_data  : cam_data;
  assign own_fs      = own_wr && (own_data == FRAME_START);
  assign switch_pend = (src_sel != active_q);
  assign drop_inc    = (&drop_q) ? drop_q : drop_q + DROP_CNT_W'(1);

  always_ff @(posedge PixelClk or negedge nRST) begin
    if (!nRST) begin
      state_q      <= S_IDLE;
      q_data_q     <= '0;
      q_wr_en_q    <= 1'b0;
      active_q     <= 1'b0;
      overflow_q   <= 1'b0;
      drop_q       <= '0;
      abort_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      q_data_q     <= q_data_d;
      q_wr_en_q    <= q_wr_en_d;
      active_q     <= active_d;
      overflow_q   <= overflow_d;
      drop_q       <= drop_d;
      abort_pend_q <= abort_pend_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    q_data_d     = q_data_q;
    q_wr_en_d    = 1'b0;
    active_d     = active_q;
    overflow_d   = overflow_q;
    drop_d       = drop_q;
    abort_pend_d = abort_pend_q;
    bump_drop    = 1'b0;

    case (state_q)
      S_IDLE: begin
        // Between frames the owner follows src_sel freely.
        active_d = src_sel;
        if (own_fs && !q_full) begin
          q_data_d  = own_data;
          q_wr_en_d = 1'b1;
          state_d   = S_STREAM;
        end
      end

      S_STREAM: begin
        if (own_fs && switch_pend) begin
          // The new owner must start with its own FRAME_START, so this one is
          // swallowed.
          active_d = src_sel;
          state_d  = S_IDLE;
        end else if (own_wr && q_full) begin
          overflow_d   = 1'b1;
          bump_drop    = 1'b1;
          abort_pend_d = 1'b1;
          state_d      = S_DROP;
        end else if (own_wr) begin
          q_data_d  = own_data;
          q_wr_en_d = 1'b1;
        end
      end

      S_DROP: begin
        if (own_fs) begin
          if (q_full) begin
            bump_drop = 1'b1;
          end else begin
            // A fresh frame makes the pending ABORT unnecessary.
            abort_pend_d = 1'b0;
            if (switch_pend) begin
              active_d = src_sel;
              state_d  = S_IDLE;
            end else begin
              q_data_d  = own_data;
              q_wr_en_d = 1'b1;
              state_d   = S_STREAM;
            end
          end
        end else if (!own_wr && abort_pend_q && !q_full) begin
          // ABORT goes out only in a gap in the owner's stream, so the
          // output stays at one write per cycle.
          q_data_d     = ABORT_WORD;
          q_wr_en_d    = 1'b1;
          abort_pend_d = 1'b0;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (bump_drop) begin
      drop_d = drop_inc;
    end

    // Clear takes priority over an increment in the same cycle.
    if (ovf_clr) begin
      overflow_d = 1'b0;
      drop_d     = '0;
    end
  end

  assign q_data     = q_data_q;
  assign q_wr_en    = q_wr_en_q;
  assign active_src = active_q;
  assign overflow   = overflow_q;
  assign drop_count = drop_q;

endmodule

// File: tb/tb_frame_queue_scheduler.sv
// Bench for frame_queue_scheduler. A behavioural model predicts every
// registered output. The stimulus is a directed sequence followed by a
// random phase.

module tb_frame_queue_scheduler;

  localparam int          W    = 8;
  localparam logic [16:0] FS   = 17'h10000;
  localparam logic [16:0] ROW  = 17'h10001;
  localparam logic [16:0] ABRT = 17'h100FF;

  logic          PixelClk = 1'b0;
  logic          nRST     = 1'b0;
  logic          src_sel  = 1'b0;
  logic [16:0]   cam_data = '0;
  logic          cam_wr_en = 1'b0;
  logic [16:0]   tp_data  = '0;
  logic          tp_wr_en = 1'b0;
  logic          q_full   = 1'b0;
  logic          ovf_clr  = 1'b0;
  logic [16:0]   q_data;
  logic          q_wr_en;
  logic          active_src;
  logic          overflow;
  logic [W-1:0]  drop_count;

  frame_queue_scheduler #(.DROP_CNT_W(W)) dut (
    .PixelClk   (PixelClk),
    .nRST       (nRST),
    .src_sel    (src_sel),
    .cam_data   (cam_data),
    .cam_wr_en  (cam_wr_en),
    .tp_data    (tp_data),
    .tp_wr_en   (tp_wr_en),
    .q_full     (q_full),
    .ovf_clr    (ovf_clr),
    .q_data     (q_data),
    .q_wr_en    (q_wr_en),
    .active_src (active_src),
    .overflow   (overflow),
    .drop_count (drop_count)
  );

  always #5 PixelClk = ~PixelClk;

  int total = 0;
  int bad   = 0;

  // Behavioural model. The model tracks whether a frame is being passed
  // through and whether one is being thrown away.
  bit          m_in_frame;
  bit          m_dropping;
  bit          m_owed_abort;
  bit          m_owner;
  bit          m_ovf;
  int          m_drops;
  bit          m_wr;
  logic [16:0] m_data;

  task automatic model_reset();
    m_in_frame   = 0;
    m_dropping   = 0;
    m_owed_abort = 0;
    m_owner      = 0;
    m_ovf        = 0;
    m_drops      = 0;
    m_wr         = 0;
    m_data       = '0;
  endtask

  task automatic emit(input logic [16:0] w);
    m_wr   = 1;
    m_data = w;
  endtask

  // Predict the effect of the inputs now applied at the next rising edge.
  task automatic model_step();
    bit          ow;
    logic [16:0] od;
    bit          fs;
    bit          lost;
    ow   = m_owner ? tp_wr_en : cam_wr_en;
    od   = m_owner ? tp_data  : cam_data;
    fs   = ow && (od == FS);
    lost = 0;
    m_wr = 0;
    if (!m_in_frame && !m_dropping) begin
      if (fs && !q_full) begin
        emit(od);
        m_in_frame = 1;
      end
      m_owner = src_sel;
    end else if (m_in_frame) begin
      if (fs && (src_sel != m_owner)) begin
        m_owner    = src_sel;
        m_in_frame = 0;
      end else if (ow && q_full) begin
        m_ovf        = 1;
        lost         = 1;
        m_owed_abort = 1;
        m_in_frame   = 0;
        m_dropping   = 1;
      end else if (ow) begin
        emit(od);
      end
    end else begin
      if (fs) begin
        if (q_full) begin
          lost = 1;
        end else begin
          m_owed_abort = 0;
          m_dropping   = 0;
          if (src_sel != m_owner) begin
            m_owner = src_sel;
          end else begin
            emit(od);
            m_in_frame = 1;
          end
        end
      end else if (!ow && m_owed_abort && !q_full) begin
        emit(ABRT);
        m_owed_abort = 0;
      end
    end
    if (lost && m_drops < (1 << W) - 1) m_drops++;
    if (ovf_clr) begin
      m_ovf   = 0;
      m_drops = 0;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, " q_wr_en"},    32'(q_wr_en),    32'(m_wr));
    chk({tag, " q_data"},     32'(q_data),     32'(m_data));
    chk({tag, " active_src"}, 32'(active_src), 32'(m_owner));
    chk({tag, " overflow"},   32'(overflow),   32'(m_ovf));
    chk({tag, " drop_count"}, 32'(drop_count), 32'(m_drops));
  endtask

  // One transaction: apply inputs, advance one clock, and compare
  // 1 time unit after the edge.
  task automatic step(input bit cv, input logic [16:0] cd, input bit tv,
                      input logic [16:0] td, input bit sel, input bit full,
                      input bit clr, input string tag);
    cam_wr_en = cv;
    cam_data  = cd;
    tp_wr_en  = tv;
    tp_data   = td;
    src_sel   = sel;
    q_full    = full;
    ovf_clr   = clr;
    model_step();
    @(posedge PixelClk);
    #1;
    check_all(tag);
    $display("%s: cam=%0b/%05h tp=%0b/%05h sel=%0b full=%0b clr=%0b -> wr=%0b data=%05h src=%0b ovf=%0b drops=%0d",
             tag, cv, cd, tv, td, sel, full, clr, q_wr_en, q_data, active_src, overflow, drop_count);
  endtask

  function automatic logic [16:0] rand_word();
    logic [31:0] r;
    int          k;
    r = $urandom();
    k = $urandom_range(0, 15);
    if (k < 2)       return FS;
    else if (k < 4)  return ROW;
    else if (k == 4) return ABRT;
    else if (k == 5) return {1'b1, r[15:0]};
    else             return {1'b0, r[15:0]};
  endfunction

  initial begin
    bit sel_r;
    model_reset();

    // Reset state
    #2;
    chk("reset q_wr_en",    32'(q_wr_en),    32'd0);
    chk("reset q_data",     32'(q_data),     32'd0);
    chk("reset active_src", 32'(active_src), 32'd0);
    chk("reset overflow",   32'(overflow),   32'd0);
    chk("reset drop_count", 32'(drop_count), 32'd0);
    @(posedge PixelClk);
    #1;
    nRST = 1'b1;

    step(0, 0, 0, 0, 0, 0, 0, "idle");

    // Camera frame passes through, one cycle late
    step(1, FS,       0, 0, 0, 0, 0, "cam_fs");
    step(1, ROW,      0, 0, 0, 0, 0, "cam_row");
    step(1, 17'h0AB12, 0, 0, 0, 0, 0, "cam_px0");
    step(1, 17'h03456, 0, 0, 0, 0, 0, "cam_px1");
    chk("cam_px1 word", 32'(q_data), 32'h03456);
    step(0, 0, 0, 0, 0, 0, 0, "gap");

    // Owner switch at frame boundary
    step(1, 17'h00111, 0, 0, 1, 0, 0, "sw_px");
    step(1, FS,        0, 0, 1, 0, 0, "sw_cam_fs");
    chk("sw_cam_fs no write", 32'(q_wr_en), 32'd0);
    step(0, 0, 1, FS, 1, 0, 0, "sw_tp_fs");
    chk("sw_tp_fs owner", 32'(active_src), 32'd1);
    step(1, 17'h00222, 1, 17'h00333, 1, 0, 0, "sw_both");
    step(1, 17'h00444, 0, 0, 1, 0, 0, "sw_cam_ignored");

    // Overflow mid-frame, ABORT emitted once, rest dropped
    step(0, 0, 1, 17'h00500, 1, 1, 0, "ovf_px");
    chk("ovf_px drop_count", 32'(drop_count), 32'd1);
    step(0, 0, 0, 0, 1, 0, 0, "abort");
    chk("abort word", 32'(q_data), 32'(ABRT));
    step(0, 0, 0, 0, 1, 0, 0, "abort_once");
    step(0, 0, 1, 17'h00501, 1, 0, 0, "drop_px");
    step(0, 0, 1, ROW, 1, 0, 0, "drop_row");
    step(0, 0, 1, FS, 1, 0, 0, "resume_fs");

    // Simultaneous strobes
    step(1, 17'h00AAA, 1, 17'h00555, 1, 0, 0, "both");
    chk("both owner data", 32'(q_data), 32'h00555);

    // Drop counter saturation and clear
    step(0, 0, 1, 17'h00600, 1, 1, 0, "sat_enter");
    for (int i = 0; i < 300; i++) step(0, 0, 1, FS, 1, 1, 0, "sat_fs");
    chk("sat drop_count", 32'(drop_count), 32'd255);
    step(0, 0, 0, 0, 1, 1, 1, "sat_clr");
    chk("sat_clr drop_count", 32'(drop_count), 32'd0);
    step(0, 0, 0, 0, 1, 0, 0, "sat_abort");

    // Reset mid-frame
    step(0, 0, 1, FS, 1, 0, 0, "rst_fs");
    step(0, 0, 1, 17'h00700, 1, 0, 0, "rst_px");
    nRST = 1'b0;
    #1;
    chk("rst q_wr_en",    32'(q_wr_en),    32'd0);
    chk("rst q_data",     32'(q_data),     32'd0);
    chk("rst active_src", 32'(active_src), 32'd0);
    chk("rst overflow",   32'(overflow),   32'd0);
    chk("rst drop_count", 32'(drop_count), 32'd0);
    model_reset();
    #2;
    nRST = 1'b1;
    step(1, 17'h00701, 0, 0, 0, 0, 0, "post_rst_cam_px");
    step(0, 0, 1, 17'h00702, 0, 0, 0, "post_rst_tp_px");
    step(1, ROW, 0, 0, 0, 0, 0, "post_rst_row");
    step(1, FS, 0, 0, 0, 0, 0, "post_rst_fs");

    // Random traffic against the model
    sel_r = 0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 31) == 0) sel_r = ~sel_r;
      step($urandom_range(0, 1) == 1, rand_word(),
           $urandom_range(0, 1) == 1, rand_word(),
           sel_r, $urandom_range(0, 4) == 0, $urandom_range(0, 63) == 0,
           "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
